// File: rtl/match_game_pkg.sv
// Shared constants for the switch-matching game: FSM encoding, LFSR taps and timing defaults.
package match_game_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DEAL   = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned DEF_CLK_HZ_DIV = 50_000_000;

endpackage

// File: rtl/match_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; shifts left with XOR feedback into bit 0.
module match_lfsr
    import match_game_pkg::*;
#(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;
    logic              w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/match_round_ctrl.sv
// Round controller: deals unbiased random targets, runs the countdown, checks guesses and
// keeps a saturating score and win streak.
module match_round_ctrl
    import match_game_pkg::*;
#(
    parameter int unsigned       N_CH       = 3,
    parameter int unsigned       SYMBOLS    = 3,
    parameter int unsigned       LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int unsigned       CLK_HZ_DIV = DEF_CLK_HZ_DIV,
    parameter int unsigned       ROUND_SECS = 30,
    parameter int unsigned       SCORE_W    = 8,
    localparam int unsigned      SYM_W      = (SYMBOLS > 2) ? $clog2(SYMBOLS) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  submit,
    input  logic [N_CH*SYM_W-1:0] guess,
    output logic [N_CH*SYM_W-1:0] target_o,
    output logic [N_CH-1:0]       match_o,
    output logic [5:0]            secs_left_o,
    output logic [SCORE_W-1:0]    score_o,
    output logic [SCORE_W-1:0]    streak_o,
    output logic                  win_o,
    output logic [2:0]            state_o,
    output logic                  busy_o
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PRE_W = (CLK_HZ_DIV > 1) ? $clog2(CLK_HZ_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [N_CH*SYM_W-1:0] r_target;
    logic [N_CH*SYM_W-1:0] r_guess;
    logic [N_CH-1:0]       r_match;
    logic [N_CH-1:0]       w_match;
    logic [5:0]            r_secs;
    logic [PRE_W-1:0]      r_presc;
    logic [SCORE_W-1:0]    r_score;
    logic [SCORE_W-1:0]    r_streak;
    logic                  r_win;

    logic [LFSR_W-1:0]     w_lfsr;
    logic [SYM_W-1:0]      w_cand;
    logic                  w_cand_ok;
    logic                  w_tick;
    logic                  w_unused_lfsr;

    match_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .q        (w_lfsr)
    );

    // Rejection sampling: out-of-range candidates are dropped so every symbol is equally likely.
    assign w_cand        = w_lfsr[SYM_W-1:0];
    assign w_cand_ok     = (32'(w_cand) < SYMBOLS);
    assign w_unused_lfsr = ^w_lfsr;
    assign w_tick        = (r_presc == PRE_W'(CLK_HZ_DIV - 1));

    always_comb begin
        w_match = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_match[k] = (r_guess[k*SYM_W +: SYM_W] == r_target[k*SYM_W +: SYM_W]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_DEAL;
            S_DEAL:   if (w_cand_ok && (r_idx == LAST_IDX)) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (submit) begin
                    w_state_nxt = S_CHECK;
                end else if (w_tick && (r_secs == 6'd0)) begin
                    w_state_nxt = S_RESULT;
                end
            end
            S_CHECK:  w_state_nxt = S_RESULT;
            S_RESULT: if (start) w_state_nxt = S_DEAL;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_target <= '0;
            r_guess  <= '0;
            r_match  <= '0;
            r_secs   <= 6'(ROUND_SECS);
            r_presc  <= '0;
            r_score  <= '0;
            r_streak <= '0;
            r_win    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE, S_RESULT: begin
                    if (start) begin
                        r_idx    <= '0;
                        r_target <= '0;
                    end
                end
                S_DEAL: begin
                    if (w_cand_ok) begin
                        r_target[r_idx*SYM_W +: SYM_W] <= w_cand;
                        r_idx                          <= r_idx + IDX_W'(1);
                        if (r_idx == LAST_IDX) begin
                            r_secs  <= 6'(ROUND_SECS);
                            r_presc <= '0;
                            r_match <= '0;
                        end
                    end
                end
                S_PLAY: begin
                    r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
                    // Submit takes priority over a coincident tick, so no decrement then.
                    if (submit) begin
                        r_guess <= guess;
                    end else if (w_tick) begin
                        if (r_secs != 6'd0) begin
                            r_secs <= r_secs - 6'd1;
                        end else begin
                            r_win    <= 1'b0;
                            r_match  <= '0;
                            r_streak <= '0;
                        end
                    end
                end
                S_CHECK: begin
                    r_match <= w_match;
                    r_win   <= &w_match;
                    if (&w_match) begin
                        if (r_score != '1)  r_score  <= r_score + SCORE_W'(1);
                        if (r_streak != '1) r_streak <= r_streak + SCORE_W'(1);
                    end else begin
                        r_streak <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign target_o    = r_target;
    assign match_o     = r_match;
    assign secs_left_o = r_secs;
    assign score_o     = r_score;
    assign streak_o    = r_streak;
    assign win_o       = r_win;
    assign state_o     = r_state;
    assign busy_o      = (r_state == S_DEAL) || (r_state == S_PLAY) || (r_state == S_CHECK);

endmodule

// File: tb/tb_match_round_ctrl.sv
// Scoreboard bench for match_round_ctrl: expected deals and round results are queued at
// stimulus time and popped when the DUT reaches PLAY or RESULT.
module tb_match_round_ctrl;

    localparam int unsigned N_CH = 3;
    localparam int unsigned SYM_W = 2;

    typedef struct packed {
        logic [2:0] match;
        logic       win;
        logic [7:0] score;
        logic [7:0] streak;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             submit;
    logic [5:0]       guess;
    logic [5:0]       target_o;
    logic [2:0]       match_o;
    logic [5:0]       secs_left_o;
    logic [7:0]       score_o;
    logic [7:0]       streak_o;
    logic             win_o;
    logic [2:0]       state_o;
    logic             busy_o;

    int               n_tests = 0;
    int               n_fail = 0;
    logic [15:0]      m_lfsr;
    logic [7:0]       m_score = 8'd0;
    logic [7:0]       m_streak = 8'd0;
    logic [5:0]       cur_target;
    logic [5:0]       tq[$];
    int               lq[$];
    res_t             rq[$];

    always #5 clk = ~clk;

    match_round_ctrl #(
        .N_CH       (3),
        .SYMBOLS    (3),
        .LFSR_W     (16),
        .SEED       (16'hACE1),
        .CLK_HZ_DIV (4),
        .ROUND_SECS (5),
        .SCORE_W    (8)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .start       (start),
        .submit      (submit),
        .guess       (guess),
        .target_o    (target_o),
        .match_o     (match_o),
        .secs_left_o (secs_left_o),
        .score_o     (score_o),
        .streak_o    (streak_o),
        .win_o       (win_o),
        .state_o     (state_o),
        .busy_o      (busy_o)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR running in lockstep with the DUT's generator.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic deal_round();
        logic [15:0] v;
        logic [5:0]  t;
        logic [1:0]  c;
        int          k;
        int          cnt;
        int          cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        v = m_lfsr;
        k = 0;
        cnt = 0;
        t = '0;
        while (k < 3) begin
            c = v[1:0];
            if (c < 2'd3) begin
                t[k*2 +: 2] = c;
                k++;
            end
            v = lfsr_step(v);
            cnt++;
        end
        tq.push_back(t);
        lq.push_back(cnt);
        n_tests++;
        if (state_o !== 3'd1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL deal_entry: state=%0d busy=%0b want state=1 busy=1", state_o, busy_o);
        end
        cyc = 0;
        while (state_o !== 3'd2 && cyc < 40) begin
            step();
            cyc++;
        end
        t = tq.pop_front();
        cnt = lq.pop_front();
        n_tests++;
        if (state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL deal_done: state=%0d want 2 within 40 cycles", state_o);
        end
        n_tests++;
        if (target_o !== t) begin
            n_fail++;
            $display("FAIL deal_target: got %h want %h", target_o, t);
        end
        n_tests++;
        if (cyc !== cnt || cyc < 3) begin
            n_fail++;
            $display("FAIL deal_latency: got %0d cycles want %0d (>=3)", cyc, cnt);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (target_o[i*2 +: 2] >= 2'd3) begin
                n_fail++;
                $display("FAIL deal_range ch%0d: got %0d want <3", i, target_o[i*2 +: 2]);
            end
        end
        n_tests++;
        if (secs_left_o !== 6'd5) begin
            n_fail++;
            $display("FAIL play_secs_init: got %0d want 5", secs_left_o);
        end
        cur_target = t;
    endtask

    task automatic submit_round(input logic [5:0] g);
        res_t e;
        res_t r;
        for (int i = 0; i < 3; i++) e.match[i] = (g[i*2 +: 2] == cur_target[i*2 +: 2]);
        e.win = &e.match;
        if (e.win) begin
            if (m_score != 8'hFF)  m_score++;
            if (m_streak != 8'hFF) m_streak++;
        end else begin
            m_streak = 8'd0;
        end
        e.score = m_score;
        e.streak = m_streak;
        rq.push_back(e);
        guess = g;
        submit = 1'b1;
        step();
        submit = 1'b0;
        n_tests++;
        if (state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL check_state: got %0d want 3", state_o);
        end
        step();
        r = rq.pop_front();
        n_tests++;
        if (state_o !== 3'd4 || match_o !== r.match || win_o !== r.win ||
            score_o !== r.score || streak_o !== r.streak) begin
            n_fail++;
            $display("FAIL result: state=%0d match=%b win=%0b score=%0d streak=%0d want 4 %b %0b %0d %0d",
                     state_o, match_o, win_o, score_o, streak_o,
                     r.match, r.win, r.score, r.streak);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (state_o !== 3'd0 || target_o !== 6'd0 || match_o !== 3'd0 || score_o !== 8'd0 ||
            streak_o !== 8'd0 || win_o !== 1'b0 || busy_o !== 1'b0 || secs_left_o !== 6'd5) begin
            n_fail++;
            $display("FAIL %s: st=%0d tgt=%h m=%b sc=%0d sk=%0d w=%0b b=%0b s=%0d want all 0, secs 5",
                     tag, state_o, target_o, match_o, score_o, streak_o, win_o, busy_o,
                     secs_left_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        submit = 1'b0;
        guess = '0;
        repeat (3) step();
        check_reset_values("reset_values");
        rst = 1'b0;
        step();
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_submit_in_idle();
        submit = 1'b1;
        step();
        submit = 1'b0;
        step();
        n_tests++;
        if (state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL submit_in_idle: state=%0d want 0", state_o);
        end
    endtask

    task automatic test_win();
        deal_round();
        submit_round(cur_target);
    endtask

    task automatic test_loss();
        logic [5:0] g;
        deal_round();
        g = cur_target;
        g[3:2] = (cur_target[3:2] == 2'd2) ? 2'd0 : cur_target[3:2] + 2'd1;
        submit_round(g);
        n_tests++;
        if (match_o !== 3'b101 || score_o !== 8'd1 || streak_o !== 8'd0) begin
            n_fail++;
            $display("FAIL loss_ch1: match=%b score=%0d streak=%0d want 101 1 0",
                     match_o, score_o, streak_o);
        end
    endtask

    task automatic test_timeout();
        res_t e;
        res_t r;
        deal_round();
        for (int s = 5; s >= 0; s--) begin
            for (int j = 0; j < 4; j++) begin
                n_tests++;
                if (secs_left_o !== 6'(s) || state_o !== 3'd2) begin
                    n_fail++;
                    $display("FAIL countdown: secs=%0d state=%0d want %0d 2", secs_left_o,
                             state_o, s);
                end
                step();
            end
        end
        m_streak = 8'd0;
        e.match = 3'b000;
        e.win = 1'b0;
        e.score = m_score;
        e.streak = m_streak;
        rq.push_back(e);
        r = rq.pop_front();
        n_tests++;
        if (state_o !== 3'd4 || match_o !== r.match || win_o !== r.win ||
            score_o !== r.score || streak_o !== r.streak || secs_left_o !== 6'd0) begin
            n_fail++;
            $display("FAIL timeout: state=%0d match=%b win=%0b score=%0d streak=%0d secs=%0d",
                     state_o, match_o, win_o, score_o, streak_o, secs_left_o);
        end
    endtask

    task automatic test_submit_at_timeout();
        deal_round();
        repeat (23) step();
        n_tests++;
        if (secs_left_o !== 6'd0 || state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_timeout: secs=%0d state=%0d want 0 2", secs_left_o, state_o);
        end
        submit_round(cur_target);
        n_tests++;
        if (secs_left_o !== 6'd0 || win_o !== 1'b1) begin
            n_fail++;
            $display("FAIL submit_at_timeout: secs=%0d win=%0b want 0 1", secs_left_o, win_o);
        end
    endtask

    task automatic test_start_in_play();
        deal_round();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_tests++;
        if (state_o !== 3'd2 || target_o !== cur_target) begin
            n_fail++;
            $display("FAIL start_in_play: state=%0d target=%h want 2 %h", state_o, target_o,
                     cur_target);
        end
    endtask

    task automatic test_mid_reset();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset_in_play");
        m_score = 8'd0;
        m_streak = 8'd0;
        tq.delete();
        lq.delete();
        rq.delete();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            deal_round();
            submit_round(cur_target);
        end
        n_tests++;
        if (score_o !== 8'd255 || streak_o !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: score=%0d streak=%0d want 255 255", score_o, streak_o);
        end
    endtask

    initial begin
        test_reset();
        test_submit_in_idle();
        test_win();
        test_loss();
        test_timeout();
        test_submit_at_timeout();
        test_start_in_play();
        test_mid_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/match_round_ctrl.md
Name: match_round_ctrl

Overview:
- Parametrised round controller for the switch-matching game.
- Deals N_CH random target symbols, each in the range 0..SYMBOLS-1, from an internal free-running LFSR using rejection sampling, so the values are unbiased.
- Runs a per-round countdown in seconds, checks the player's submitted guesses per channel, and keeps a saturating score and win streak.
- Sits between the board I/O (switches/keys feeding guess/start/submit) and the hex/LED display decoders.

Parameters:
- N_CH, 3, number of target channels.
- SYMBOLS, 3, symbols per channel (2..16); SYM_W = max(1, clog2(SYMBOLS)) is a derived localparam.
- LFSR_W, 16, LFSR width; fixed taps 16,14,13,11 (Fibonacci, XOR); only 16 is supported.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- CLK_HZ_DIV, 50_000_000, clock cycles per one-second tick.
- ROUND_SECS, 30, countdown start value; must be <= 63.
- SCORE_W, 8, width of score and streak.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a round from IDLE or RESULT.
- submit  in  1  one-cycle pulse; locks in guess during PLAY.
- guess  in  N_CH*SYM_W  player guesses; channel k occupies bits [k*SYM_W +: SYM_W].
- target_o  out  N_CH*SYM_W  dealt symbols, same packing as guess.
- match_o  out  N_CH  per-channel match mask from the last check.
- secs_left_o  out  6  remaining seconds.
- score_o  out  SCORE_W  rounds won, saturating.
- streak_o  out  SCORE_W  consecutive wins, saturating.
- win_o  out  1  last round result: 1 = all channels matched.
- state_o  out  3  encoded FSM state.
- busy_o  out  1  high in DEAL, PLAY and CHECK.

Behaviour:
- Reset (async) values:
  - FSM = IDLE.
  - LFSR = SEED.
  - target_o, match_o, score_o, streak_o, win_o, busy_o = 0.
  - secs_left_o = ROUND_SECS.
  - Prescaler = 0.
- LFSR:
  - Advances every cycle in every state, including IDLE.
  - Feedback = b15^b13^b12^b10; shifts left with feedback into b0.
  - The state never becomes zero.
- FSM encoding: IDLE=0, DEAL=1, PLAY=2, CHECK=3, RESULT=4.
- IDLE:
  - start -> DEAL.
  - Channel index idx cleared to 0 and target_o cleared on the transition.
- DEAL, one candidate per cycle:
  - Candidate = LFSR[SYM_W-1:0].
  - If candidate < SYMBOLS: store it in channel idx and increment idx. Otherwise reject it and retry next cycle.
  - After channel N_CH-1 is stored -> PLAY.
  - On entry to PLAY: secs_left = ROUND_SECS, prescaler = 0, match_o cleared.
  - Latency is at least N_CH cycles.
- PLAY:
  - The prescaler counts 0..CLK_HZ_DIV-1; tick is asserted in the cycle it wraps.
  - On tick with secs_left > 0: decrement secs_left.
  - On tick with secs_left == 0: timeout -> RESULT with win_o = 0, match_o = 0, streak cleared.
  - submit -> CHECK, latching guess. The first tick is therefore CLK_HZ_DIV cycles after PLAY entry.
  - submit and timeout in the same cycle: submit wins, and secs_left is not decremented in that cycle.
- CHECK (exactly 1 cycle):
  - match_o[k] = (guess_latched[k] == target[k]).
  - win_o = &match_o.
  - On a win: score +1 and streak +1, each saturating at 2^SCORE_W-1.
  - On a loss: streak = 0.
  - -> RESULT.
  - Result outputs are visible 2 cycles after the submit pulse.
- RESULT:
  - Holds target_o, match_o, win_o and secs_left_o.
  - start -> DEAL; score and streak are kept.
- Ignored inputs:
  - start outside IDLE/RESULT is ignored.
  - submit outside PLAY is ignored.
  - guess is sampled only on the accepted submit.
- guess values >= SYMBOLS are legal input and simply mismatch.
- Reset asserted mid-round returns all state, including score, to reset values immediately.
- secs_left_o is frozen outside PLAY.

Decomposition:
- Shared package match_game_pkg holds:
  - state encoding constants.
  - LFSR tap mask.
  - the default CLK_HZ_DIV.
- Sub-module match_lfsr (params LFSR_W, SEED; ports CLOCK_50, reset, q):
  - Free-running.
  - Reusable by other game blocks.
- The prescaler and countdown stay inline.

Test Plan:
1. Bench parameters for all scenarios: N_CH=3, SYMBOLS=3, CLK_HZ_DIV=4, ROUND_SECS=5, SEED=16'hACE1.
2. Reset, then start pulse:
   - DEAL lasts at least 3 cycles.
   - Every target field is < 3.
   - The target sequence matches a reference LFSR model including rejections of value 3.
   - state_o = 2 after dealing.
3. Drive guess = target_o, then submit:
   - 2 cycles later: match_o = 3'b111, win_o = 1, score_o = 1, streak_o = 1, state_o = 4.
4. Second round with channel 1 wrong:
   - match_o = 3'b101, win_o = 0, score_o stays 1, streak_o = 0.
5. No submit:
   - secs_left_o steps 5,4,3,2,1,0 every 4 cycles.
   - On the next tick: state_o = 4, win_o = 0, match_o = 0.
   - Timeout occurs 24 cycles after PLAY entry.
6. submit coincident with the timeout tick:
   - CHECK is taken and the result is evaluated.
   - secs_left_o stays 0.
7. Edge cases:
   - reset asserted during PLAY: outputs return to reset values asynchronously, score_o = 0.
   - start during PLAY and submit during IDLE: no state change.
   - 256 consecutive wins with SCORE_W=8: score_o saturates at 255.
